// File: rtl/minmax_pkg.sv
// minmax_pkg: shared types and defaults for the min/max tracker.
// Holds the FSM state enum and default WIDTH/WINDOW values.
package minmax_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_TRACK  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_WINDOW = 8;

endpackage

// File: rtl/minmax_cmp.sv
// minmax_cmp: unsigned WIDTH-bit magnitude comparator.
// Ports: a, b in; eq (a==b), gt (a>b), lt (a<b) out.
module minmax_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/minmax_tracker.sv
// minmax_tracker: reports max/min of each WINDOW-sample block.
// Ports: clk, rst_n (sync, active-low), clear; in_valid/in_ready/
// in_data sample input; out_valid/out_ready/out_max/out_min
// report. Macro MINMAX_TIE_COUNT_EN adds tie_cnt (count of max).
module minmax_tracker
  import minmax_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WINDOW = DEF_WINDOW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min
`ifdef MINMAX_TIE_COUNT_EN
  ,
  output logic [7:0]       tie_cnt
`endif
);

  localparam logic [7:0] WIN = 8'(WINDOW);

  state_t           state;
  logic [7:0]       cnt;
  logic [7:0]       cnt_nxt;
  logic [WIDTH-1:0] cur_max;
  logic [WIDTH-1:0] cur_min;
  logic [WIDTH-1:0] nxt_max;
  logic [WIDTH-1:0] nxt_min;
  logic             acc;
  logic             first;
  logic             last;
  logic             max_eq, max_gt, max_lt;
  logic             min_eq, min_gt, min_lt;

  minmax_cmp #(.WIDTH(WIDTH)) u_cmp_max (
    .a  (in_data),
    .b  (cur_max),
    .eq (max_eq),
    .gt (max_gt),
    .lt (max_lt)
  );

  minmax_cmp #(.WIDTH(WIDTH)) u_cmp_min (
    .a  (in_data),
    .b  (cur_min),
    .eq (min_eq),
    .gt (min_gt),
    .lt (min_lt)
  );

  assign in_ready  = (state != ST_REPORT);
  assign out_valid = (state == ST_REPORT);
  assign acc       = in_valid & in_ready;
  assign first     = (state == ST_EMPTY);
  assign cnt_nxt   = first ? 8'd1 : cnt + 8'd1;
  assign last      = (cnt_nxt >= WIN);

  // Equal samples leave both extremes untouched.
  always_comb begin
    nxt_max = cur_max;
    nxt_min = cur_min;
    if (first) begin
      nxt_max = in_data;
      nxt_min = in_data;
    end else begin
      if (max_gt) nxt_max = in_data;
      if (min_lt) nxt_min = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_EMPTY;
      cnt     <= '0;
      cur_max <= '0;
      cur_min <= '0;
      out_max <= '0;
      out_min <= '0;
    end else if (clear) begin
      state <= ST_EMPTY;
      cnt   <= '0;
    end else begin
      unique case (1'b1)
        acc: begin
          cnt     <= cnt_nxt;
          cur_max <= nxt_max;
          cur_min <= nxt_min;
          if (last) begin
            state   <= ST_REPORT;
            out_max <= nxt_max;
            out_min <= nxt_min;
          end else begin
            state <= ST_TRACK;
          end
        end
        (out_valid && out_ready): begin
          state <= ST_EMPTY;
          cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef MINMAX_TIE_COUNT_EN
  logic [7:0] tie_run;
  logic [7:0] tie_nxt;

  // Run restarts on a new maximum, grows on a repeat of it.
  always_comb begin
    tie_nxt = tie_run;
    if (first || max_gt) tie_nxt = 8'd1;
    else if (max_eq)     tie_nxt = tie_run + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tie_run <= '0;
      tie_cnt <= '0;
    end else if (clear) begin
      tie_run <= '0;
    end else if (acc) begin
      tie_run <= tie_nxt;
      if (last) tie_cnt <= tie_nxt;
    end
  end

  logic unused_cmp;
  assign unused_cmp = ^{max_lt, min_gt, min_eq};
`else
  logic unused_cmp;
  assign unused_cmp = ^{max_eq, max_lt, min_gt, min_eq};
`endif

endmodule

// File: tb/tb_minmax_tracker.sv
// tb_minmax_tracker: scoreboard bench for minmax_tracker.
// WIDTH=4, WINDOW=4; tie_cnt checked when MINMAX_TIE_COUNT_EN set.
module tb_minmax_tracker;

  typedef struct packed {
    logic [3:0] mx;
    logic [3:0] mn;
    logic [7:0] tie;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       clear;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_max;
  logic [3:0] out_min;
`ifdef MINMAX_TIE_COUNT_EN
  logic [7:0] tie_cnt;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [3:0] last_mx = '0;
  logic [3:0] last_mn = '0;

  minmax_tracker #(.WIDTH(4), .WINDOW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_min   (out_min)
`ifdef MINMAX_TIE_COUNT_EN
    ,
    .tie_cnt   (tie_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives four back-to-back samples and pushes the model result.
  task automatic feed(input logic [3:0] a, b, c, d);
    logic [3:0] s [4];
    exp_t e;
    s[0] = a; s[1] = b; s[2] = c; s[3] = d;
    e.mx = a; e.mn = a; e.tie = 8'd1;
    for (int i = 1; i < 4; i++) begin
      if (s[i] > e.mx) begin
        e.mx = s[i];
        e.tie = 8'd1;
      end else if (s[i] == e.mx) begin
        e.tie = e.tie + 8'd1;
      end
      if (s[i] < e.mn) e.mn = s[i];
    end
    sb.push_back(e);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = s[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Bounded wait for a report; pops the expected entry.
  task automatic get_report(output exp_t e, output bit ok);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    ok = (out_valid === 1'b1) && (sb.size() > 0);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '0;
  endtask

  task automatic consume;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    clear = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got %b want 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: got %b want 1", in_ready);
    end
    checks++;
    if (out_max !== 4'd0 || out_min !== 4'd0) begin
      errors++;
      $display("FAIL rst_out: got %0d/%0d want 0/0", out_max, out_min);
    end
`ifdef MINMAX_TIE_COUNT_EN
    checks++;
    if (tie_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_tie: got %0d want 0", tie_cnt);
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    exp_t e;
    bit ok;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 4'd5; tick();
    in_data = 4'd3; tick();
    in_data = 4'd9; tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_valid: got %b want 0", out_valid);
    end
    in_data = 4'd7; tick();
    in_valid = 1'b0;
    sb.push_back('{mx: 4'd9, mn: 4'd3, tie: 8'd1});
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: got %b want 1", out_valid);
    end
    get_report(e, ok);
    checks++;
    if (!ok || out_max !== e.mx || out_min !== e.mn) begin
      errors++;
      $display("FAIL basic: got %0d/%0d want %0d/%0d",
               out_max, out_min, e.mx, e.mn);
    end
`ifdef MINMAX_TIE_COUNT_EN
    checks++;
    if (tie_cnt !== e.tie) begin
      errors++;
      $display("FAIL basic_tie: got %0d want %0d", tie_cnt, e.tie);
    end
`endif
    last_mx = e.mx; last_mn = e.mn;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL consume: valid=%b ready=%b want 0/1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_ties;
    exp_t e;
    bit ok;
    feed(4'd6, 4'd6, 4'd6, 4'd6);
    get_report(e, ok);
    checks++;
    if (!ok || out_max !== e.mx || out_min !== e.mn) begin
      errors++;
      $display("FAIL equal: got %0d/%0d want %0d/%0d",
               out_max, out_min, e.mx, e.mn);
    end
`ifdef MINMAX_TIE_COUNT_EN
    checks++;
    if (tie_cnt !== e.tie) begin
      errors++;
      $display("FAIL equal_tie: got %0d want %0d", tie_cnt, e.tie);
    end
`endif
    consume();
    feed(4'd0, 4'd15, 4'd15, 4'd0);
    get_report(e, ok);
    checks++;
    if (!ok || out_max !== e.mx || out_min !== e.mn) begin
      errors++;
      $display("FAIL extremes: got %0d/%0d want %0d/%0d",
               out_max, out_min, e.mx, e.mn);
    end
`ifdef MINMAX_TIE_COUNT_EN
    checks++;
    if (tie_cnt !== e.tie) begin
      errors++;
      $display("FAIL extremes_tie: got %0d want %0d", tie_cnt, e.tie);
    end
`endif
    last_mx = e.mx; last_mn = e.mn;
    consume();
  endtask

  task automatic test_hold;
    exp_t e;
    bit ok;
    feed(4'd1, 4'd2, 4'd3, 4'd4);
    get_report(e, ok);
    checks++;
    if (!ok || out_max !== e.mx || out_min !== e.mn) begin
      errors++;
      $display("FAIL hold_rep: got %0d/%0d want %0d/%0d",
               out_max, out_min, e.mx, e.mn);
    end
    in_valid = 1'b1; in_data = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          out_max !== e.mx || out_min !== e.mn) begin
        errors++;
        $display("FAIL hold%0d: v=%b r=%b %0d/%0d want 1/0 %0d/%0d",
                 i, out_valid, in_ready, out_max, out_min, e.mx, e.mn);
      end
    end
    in_valid = 1'b0;
    last_mx = e.mx; last_mn = e.mn;
    consume();
    feed(4'd10, 4'd11, 4'd12, 4'd13);
    get_report(e, ok);
    checks++;
    if (!ok || out_max !== e.mx || out_min !== e.mn) begin
      errors++;
      $display("FAIL after_hold: got %0d/%0d want %0d/%0d",
               out_max, out_min, e.mx, e.mn);
    end
    last_mx = e.mx; last_mn = e.mn;
    consume();
  endtask

  task automatic test_clear;
    exp_t e;
    bit ok;
    in_valid = 1'b1; in_data = 4'd15; tick();
    in_data = 4'd0; tick();
    in_valid = 1'b0;
    clear = 1'b1; tick();
    clear = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_max !== last_mx ||
        out_min !== last_mn) begin
      errors++;
      $display("FAIL clear_mid: v=%b %0d/%0d want 0 %0d/%0d",
               out_valid, out_max, out_min, last_mx, last_mn);
    end
    feed(4'd2, 4'd4, 4'd1, 4'd3);
    get_report(e, ok);
    checks++;
    if (!ok || out_max !== e.mx || out_min !== e.mn) begin
      errors++;
      $display("FAIL clear_win: got %0d/%0d want %0d/%0d",
               out_max, out_min, e.mx, e.mn);
    end
`ifdef MINMAX_TIE_COUNT_EN
    checks++;
    if (tie_cnt !== e.tie) begin
      errors++;
      $display("FAIL clear_tie: got %0d want %0d", tie_cnt, e.tie);
    end
`endif
    last_mx = e.mx; last_mn = e.mn;
    consume();
  endtask

  task automatic test_clear_report;
    exp_t e;
    bit ok;
    feed(4'd7, 4'd1, 4'd7, 4'd2);
    get_report(e, ok);
    checks++;
    if (!ok || out_max !== e.mx || out_min !== e.mn) begin
      errors++;
      $display("FAIL crep_rep: got %0d/%0d want %0d/%0d",
               out_max, out_min, e.mx, e.mn);
    end
    clear = 1'b1; out_ready = 1'b1; tick();
    clear = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        out_max !== e.mx || out_min !== e.mn) begin
      errors++;
      $display("FAIL crep_drop: v=%b r=%b %0d/%0d want 0/1 %0d/%0d",
               out_valid, in_ready, out_max, out_min, e.mx, e.mn);
    end
  endtask

  task automatic test_reset_report;
    exp_t e;
    bit ok;
    feed(4'd9, 4'd9, 4'd2, 4'd1);
    get_report(e, ok);
    checks++;
    if (!ok || out_max !== e.mx || out_min !== e.mn) begin
      errors++;
      $display("FAIL rrep_rep: got %0d/%0d want %0d/%0d",
               out_max, out_min, e.mx, e.mn);
    end
    rst_n = 1'b0; out_ready = 1'b1; tick();
    rst_n = 1'b1; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        out_max !== 4'd0 || out_min !== 4'd0) begin
      errors++;
      $display("FAIL rrep_rst: v=%b r=%b %0d/%0d want 0/1 0/0",
               out_valid, in_ready, out_max, out_min);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_hold();
    test_clear();
    test_clear_report();
    test_reset_report();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
